// File: rtl/fpga_final_pkg.sv
// Shared constants and types for the game-core input front end.
package fpga_final_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  localparam int unsigned BTN_LEFT      = 0;
  localparam int unsigned BTN_RIGHT     = 1;
  localparam int unsigned BTN_THROW     = 2;
  localparam int unsigned N_BTN_DEFAULT = 3;

  localparam int unsigned DEBOUNCE_CYC_DEFAULT     = 500_000;
  localparam int unsigned REPEAT_DELAY_CYC_DEFAULT = 25_000_000;
  localparam int unsigned REPEAT_RATE_CYC_DEFAULT  = 5_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_RPT   = 2'd2
  } rpt_state_e;

endpackage

// File: rtl/button_event_gen_if.sv
// Button pins in, conditioned button events out.
interface button_event_gen_if #(
  parameter int unsigned N_BTN = 3
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] repeat_en;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_event;

  modport master (
    output btn_raw, repeat_en,
    input  btn_level, btn_press, btn_release, btn_event
  );

  modport slave (
    input  btn_raw, repeat_en,
    output btn_level, btn_press, btn_release, btn_event
  );
endinterface

// File: rtl/button_event_gen_channel.sv
// One button: 2-FF synchronizer, debounce filter, edge pulses and auto-repeat FSM.
module btn_channel
  import fpga_final_pkg::*;
#(
  parameter bit          BTN_ACTIVE_LOW   = 1'b0,
  parameter int unsigned DEBOUNCE_CYC     = DEBOUNCE_CYC_DEFAULT,
  parameter int unsigned REPEAT_DELAY_CYC = REPEAT_DELAY_CYC_DEFAULT,
  parameter int unsigned REPEAT_RATE_CYC  = REPEAT_RATE_CYC_DEFAULT
) (
  input  logic CLK,
  input  logic reset_n,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_event
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned RP_MAX = (REPEAT_DELAY_CYC > REPEAT_RATE_CYC) ? REPEAT_DELAY_CYC
                                                                        : REPEAT_RATE_CYC;
  localparam int unsigned RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

  localparam logic [DB_W-1:0] DB_TC    = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [RP_W-1:0] DELAY_TC = RP_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [RP_W-1:0] RATE_TC  = RP_W'(REPEAT_RATE_CYC - 1);

  logic [1:0]      sync_q, sync_d;
  logic [DB_W-1:0] cnt_db_q, cnt_db_d;
  logic [RP_W-1:0] cnt_rp_q, cnt_rp_d;
  logic            level_q, level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            event_q, event_d;
  rpt_state_e      state_q, state_d;
  logic            s;

  assign sync_d = {sync_q[0], btn_raw};
  assign s      = sync_q[1] ^ BTN_ACTIVE_LOW;

  always_comb begin
    cnt_db_d  = cnt_db_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (s == level_q) begin
      cnt_db_d = '0;
    end else if (cnt_db_q == DB_TC) begin
      cnt_db_d  = '0;
      level_d   = s;
      press_d   = s;
      release_d = ~s;
    end else begin
      cnt_db_d = cnt_db_q + DB_W'(1);
    end
  end

  // FSM reacts to this cycle's accepted edges so btn_event lines up with btn_press.
  always_comb begin
    state_d  = state_q;
    cnt_rp_d = cnt_rp_q;
    event_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press_d) begin
          event_d  = 1'b1;
          cnt_rp_d = '0;
          state_d  = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (release_d) begin
          state_d = ST_IDLE;
        end else if (repeat_en) begin
          if (cnt_rp_q == DELAY_TC) begin
            event_d  = 1'b1;
            cnt_rp_d = '0;
            state_d  = ST_RPT;
          end else begin
            cnt_rp_d = cnt_rp_q + RP_W'(1);
          end
        end
      end
      ST_RPT: begin
        if (release_d) begin
          state_d = ST_IDLE;
        end else if (repeat_en) begin
          if (cnt_rp_q == RATE_TC) begin
            event_d  = 1'b1;
            cnt_rp_d = '0;
          end else begin
            cnt_rp_d = cnt_rp_q + RP_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= {2{BTN_ACTIVE_LOW}};
      cnt_db_q  <= '0;
      cnt_rp_q  <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      event_q   <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      sync_q    <= sync_d;
      cnt_db_q  <= cnt_db_d;
      cnt_rp_q  <= cnt_rp_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      event_q   <= event_d;
      state_q   <= state_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_event   = event_q;

endmodule

// File: rtl/button_event_gen.sv
// Input front end: N_BTN independent button channels, no shared logic.
module button_event_gen
  import fpga_final_pkg::*;
#(
  parameter int unsigned N_BTN            = N_BTN_DEFAULT,
  parameter bit          BTN_ACTIVE_LOW   = 1'b0,
  parameter int unsigned DEBOUNCE_CYC     = DEBOUNCE_CYC_DEFAULT,
  parameter int unsigned REPEAT_DELAY_CYC = REPEAT_DELAY_CYC_DEFAULT,
  parameter int unsigned REPEAT_RATE_CYC  = REPEAT_RATE_CYC_DEFAULT
) (
  input  logic               CLK,
  input  logic               reset_n,
  button_event_gen_if.slave  bus
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_channel #(
      .BTN_ACTIVE_LOW   (BTN_ACTIVE_LOW),
      .DEBOUNCE_CYC     (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC (REPEAT_DELAY_CYC),
      .REPEAT_RATE_CYC  (REPEAT_RATE_CYC)
    ) u_ch (
      .CLK         (CLK),
      .reset_n     (reset_n),
      .btn_raw     (bus.btn_raw[i]),
      .repeat_en   (bus.repeat_en[i]),
      .btn_level   (bus.btn_level[i]),
      .btn_press   (bus.btn_press[i]),
      .btn_release (bus.btn_release[i]),
      .btn_event   (bus.btn_event[i])
    );
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Directed bench for button_event_gen with short debounce/repeat timings.
module tb_button_event_gen;

  logic CLK = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   passes = 0;
  int   n_press;
  int   n_event;

  always #5 CLK = ~CLK;

  button_event_gen_if #(.N_BTN(3)) bus ();

  button_event_gen #(
    .N_BTN            (3),
    .BTN_ACTIVE_LOW   (1'b0),
    .DEBOUNCE_CYC     (4),
    .REPEAT_DELAY_CYC (10),
    .REPEAT_RATE_CYC  (3)
  ) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"},   bus.btn_level,   3'b000);
    chk({tag, "_press"},   bus.btn_press,   3'b000);
    chk({tag, "_release"}, bus.btn_release, 3'b000);
    chk({tag, "_event"},   bus.btn_event,   3'b000);
  endtask

  initial begin
    // 1: reset with all buttons held, then first press 6 cycles after release
    reset_n       = 1'b0;
    bus.btn_raw   = 3'b111;
    bus.repeat_en = 3'b000;
    step(3);
    chk_all_zero("rst");
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("rst_early_press", bus.btn_press, 3'b000);
    end
    step(1);
    chk("rst_press6", bus.btn_press, 3'b111);
    chk("rst_event6", bus.btn_event, 3'b111);
    chk("rst_level6", bus.btn_level, 3'b111);
    step(1);
    chk("rst_press_1cyc", bus.btn_press, 3'b000);
    chk("rst_no_repeat", bus.btn_event, 3'b000);
    bus.btn_raw = 3'b000;
    step(6);
    chk("rst_release6", bus.btn_release, 3'b111);
    chk("rst_rel_level", bus.btn_level, 3'b000);
    chk("rst_rel_event", bus.btn_event, 3'b000);
    step(1);
    chk("rst_release_1cyc", bus.btn_release, 3'b000);
    step(3);

    // 2: bouncing left button, one accepted press at T+6
    n_press = 0;
    n_event = 0;
    for (int b = 0; b < 4; b++) begin
      bus.btn_raw[0] = (b % 2 == 0);
      for (int c = 0; c < 2; c++) begin
        step(1);
        n_press += int'(bus.btn_press[0]);
        n_event += int'(bus.btn_event[0]);
      end
    end
    bus.btn_raw[0] = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      n_press += int'(bus.btn_press[0]);
      n_event += int'(bus.btn_event[0]);
      if (k == 6) chk("bounce_press_T6", bus.btn_press, 3'b001);
    end
    chk("bounce_press_count", 3'(n_press), 3'd1);
    chk("bounce_event_count", 3'(n_event), 3'd1);

    // 5: 3-cycle low glitch ignored, then sustained release
    bus.btn_raw[0] = 1'b0;
    step(3);
    bus.btn_raw[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step(1);
      chk("glitch_level", bus.btn_level, 3'b001);
      chk("glitch_release", bus.btn_release, 3'b000);
    end
    bus.btn_raw[0] = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      chk("rel_event", bus.btn_event, 3'b000);
      chk("rel_release", bus.btn_release, (k == 6) ? 3'b001 : 3'b000);
      chk("rel_level", bus.btn_level, (k == 6) ? 3'b000 : 3'b001);
    end
    step(3);

    // 3: right button held with repeat enabled; release lands on a repeat terminal count
    bus.repeat_en[1] = 1'b1;
    bus.btn_raw[1]   = 1'b1;
    step(6);
    chk("rpt_t0_event", bus.btn_event, 3'b010);
    chk("rpt_t0_press", bus.btn_press, 3'b010);
    n_event = 1;
    for (int k = 1; k <= 31; k++) begin
      step(1);
      chk("rpt_event", bus.btn_event, (k >= 10 && (k - 10) % 3 == 0) ? 3'b010 : 3'b000);
      if (k <= 28) n_event += int'(bus.btn_event[1]);
    end
    chk("rpt_count_to_28", 3'(n_event), 3'd0 + 3'(8));
    bus.btn_raw[1] = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      step(1);
      chk("rpt_rel_event", bus.btn_event, (j == 3) ? 3'b010 : 3'b000);
      chk("rpt_rel_release", bus.btn_release, (j == 6) ? 3'b010 : 3'b000);
    end
    bus.repeat_en[1] = 1'b0;
    step(3);

    // 4: throw held with repeat disabled, enable raised at t0+20
    bus.btn_raw[2] = 1'b1;
    step(6);
    chk("hold_t0_event", bus.btn_event, 3'b100);
    for (int k = 1; k <= 33; k++) begin
      step(1);
      chk("hold_event", bus.btn_event, (k == 30 || k == 33) ? 3'b100 : 3'b000);
      if (k == 20) bus.repeat_en[2] = 1'b1;
    end
    bus.repeat_en[2] = 1'b0;
    bus.btn_raw[2]   = 1'b0;
    step(6);
    chk("hold_release", bus.btn_release, 3'b100);
    chk("hold_rel_event", bus.btn_event, 3'b000);
    step(3);

    // 6: simultaneous left+right press, then reset mid-hold
    bus.btn_raw = 3'b011;
    step(5);
    chk("sim_press_early", bus.btn_press, 3'b000);
    step(1);
    chk("sim_press", bus.btn_press, 3'b011);
    chk("sim_event", bus.btn_event, 3'b011);
    step(2);
    chk("sim_level", bus.btn_level, 3'b011);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    step(2);
    chk_all_zero("midrst_hold");
    bus.btn_raw = 3'b000;
    #2;
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(1);
      chk("post_rst_release", bus.btn_release, 3'b000);
      chk("post_rst_press", bus.btn_press, 3'b000);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
